// File: rtl/wb_stage_fwd.sv
// Writeback stage with load alignment/extension, committed-write history and
// decode bypass lookup, plus a retired-instruction counter.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-low reset
//   MEM_WB_*           MEM/WB pipeline register contents for the instruction in WB
//   q_rs               NRD packed lookup indices, port i at [i*RBITS +: RBITS]
//   WB_data/WB_rd      register-file write data / index (index 0 when not valid)
//   WB_misalign        load offset not aligned to its size (informational)
//   q_hit/q_data       per-port bypass hit and data
//   instret            retired-instruction count

module wb_stage_fwd #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RBITS      = 5,
  parameter int unsigned HIST_DEPTH = 2,
  parameter int unsigned NRD        = 2,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       MEM_WB_alu_res,
  input  logic [XLEN-1:0]       MEM_WB_mem_dout,
  input  logic [XLEN-1:0]       MEM_WB_pc4,
  input  logic [XLEN-1:0]       MEM_WB_csr,
  input  logic [1:0]            MEM_WB_wb_sel,
  input  logic [1:0]            MEM_WB_size,
  input  logic                  MEM_WB_unsigned,
  input  logic                  MEM_WB_vld,
  input  logic [RBITS-1:0]      MEM_WB_rd,
  input  logic [NRD*RBITS-1:0]  q_rs,
  output logic [XLEN-1:0]       WB_data,
  output logic [RBITS-1:0]      WB_rd,
  output logic                  WB_misalign,
  output logic [NRD-1:0]        q_hit,
  output logic [NRD*XLEN-1:0]   q_data,
  output logic [CNT_W-1:0]      instret
);

  localparam int unsigned OB = $clog2(XLEN / 8);

  // Load path
  logic [OB-1:0]   off;
  logic [OB-1:0]   low_mask;     // offset bits that must be zero for this size
  logic [OB-1:0]   aligned_off;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;         // bits belonging to the loaded value
  logic [XLEN-1:0] ld_data;
  logic            sign_bit;
  logic            ext_bit;

  logic unused_alu_hi;
  assign unused_alu_hi = ^MEM_WB_alu_res[XLEN-1:OB];

  always_comb begin
    off = MEM_WB_alu_res[OB-1:0];
    case (MEM_WB_size)
      2'b00: begin
        low_mask = '0;
        keep     = XLEN'(8'hFF);
      end
      2'b01: begin
        low_mask = OB'(1);
        keep     = XLEN'(16'hFFFF);
      end
      2'b10: begin
        low_mask = OB'(3);
        keep     = XLEN'(32'hFFFF_FFFF);
      end
      default: begin
        // Dword: whole datapath; on XLEN=32 this is identical to a word load.
        low_mask = '1;
        keep     = '1;
      end
    endcase
    aligned_off = off & ~low_mask;
    shifted     = MEM_WB_mem_dout >> {aligned_off, 3'b000};
    case (MEM_WB_size)
      2'b00:   sign_bit = shifted[7];
      2'b01:   sign_bit = shifted[15];
      2'b10:   sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
    ext_bit = sign_bit & ~MEM_WB_unsigned;
    ld_data = (shifted & keep) | ({XLEN{ext_bit}} & ~keep);
  end

  assign WB_misalign = (MEM_WB_wb_sel == 2'b01) & MEM_WB_vld & (|(off & low_mask));

  always_comb begin
    case (MEM_WB_wb_sel)
      2'b00:   WB_data = MEM_WB_alu_res;
      2'b01:   WB_data = ld_data;
      2'b10:   WB_data = MEM_WB_pc4;
      default: WB_data = MEM_WB_csr;
    endcase
  end

  assign WB_rd = MEM_WB_vld ? MEM_WB_rd : '0;

  logic commit;
  assign commit = MEM_WB_vld & (MEM_WB_rd != '0);

  // History, entry 0 newest
  logic             hist_vld_q  [HIST_DEPTH];
  logic             hist_vld_d  [HIST_DEPTH];
  logic [RBITS-1:0] hist_rd_q   [HIST_DEPTH];
  logic [RBITS-1:0] hist_rd_d   [HIST_DEPTH];
  logic [XLEN-1:0]  hist_data_q [HIST_DEPTH];
  logic [XLEN-1:0]  hist_data_d [HIST_DEPTH];

  always_comb begin
    hist_vld_d  = hist_vld_q;
    hist_rd_d   = hist_rd_q;
    hist_data_d = hist_data_q;
    if (commit) begin
      hist_vld_d[0]  = 1'b1;
      hist_rd_d[0]   = WB_rd;
      hist_data_d[0] = WB_data;
      for (int unsigned k = 1; k < HIST_DEPTH; k++) begin
        hist_vld_d[k]  = hist_vld_q[k-1];
        hist_rd_d[k]   = hist_rd_q[k-1];
        hist_data_d[k] = hist_data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
        hist_vld_q[k] <= 1'b0;
      end
    end else begin
      hist_vld_q <= hist_vld_d;
    end
  end

  // Payload is only meaningful under its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    hist_rd_q   <= hist_rd_d;
    hist_data_q <= hist_data_d;
  end

  // Retired-instruction counter
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  assign instret_d = instret_q + CNT_W'(MEM_WB_vld);

  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

  // Bypass lookup: scan oldest to newest so later (newer) matches override,
  // with the current-cycle commit applied last. History is ignored while in
  // reset since it is being cleared on this edge.
  logic [RBITS-1:0] rs_cur;

  always_comb begin
    q_hit  = '0;
    q_data = '0;
    rs_cur = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rs_cur = q_rs[i*RBITS +: RBITS];
      if (rst) begin
        for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
          if (hist_vld_q[k] && (hist_rd_q[k] == rs_cur)) begin
            q_hit[i]              = 1'b1;
            q_data[i*XLEN +: XLEN] = hist_data_q[k];
          end
        end
      end
      if (commit && (WB_rd == rs_cur)) begin
        q_hit[i]              = 1'b1;
        q_data[i*XLEN +: XLEN] = WB_data;
      end
      if (rs_cur == '0) begin
        q_hit[i]              = 1'b0;
        q_data[i*XLEN +: XLEN] = '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_fwd.sv
// Testbench for wb_stage_fwd: two instances (XLEN=32/depth 2/CNT_W=4 and
// XLEN=64/depth 3/CNT_W=8) driven by shared stimulus and compared against a
// queue-based reference model.

module tb_wb_stage_fwd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] alu, mem, pc, csr;
  logic [1:0]  sel, size;
  logic        uns, vld;
  logic [4:0]  rd;
  logic [9:0]  q_rs;

  logic [31:0]  wb_data32;
  logic [4:0]   wb_rd32;
  logic         mis32;
  logic [1:0]   hit32;
  logic [63:0]  qd32;
  logic [3:0]   ir32;

  logic [63:0]  wb_data64;
  logic [4:0]   wb_rd64;
  logic         mis64;
  logic [1:0]   hit64;
  logic [127:0] qd64;
  logic [7:0]   ir64;

  wb_stage_fwd #(
    .XLEN(32), .RBITS(5), .HIST_DEPTH(2), .NRD(2), .CNT_W(4)
  ) u_dut32 (
    .clk            (clk),
    .rst            (rst),
    .MEM_WB_alu_res (alu[31:0]),
    .MEM_WB_mem_dout(mem[31:0]),
    .MEM_WB_pc4     (pc[31:0]),
    .MEM_WB_csr     (csr[31:0]),
    .MEM_WB_wb_sel  (sel),
    .MEM_WB_size    (size),
    .MEM_WB_unsigned(uns),
    .MEM_WB_vld     (vld),
    .MEM_WB_rd      (rd),
    .q_rs           (q_rs),
    .WB_data        (wb_data32),
    .WB_rd          (wb_rd32),
    .WB_misalign    (mis32),
    .q_hit          (hit32),
    .q_data         (qd32),
    .instret        (ir32)
  );

  wb_stage_fwd #(
    .XLEN(64), .RBITS(5), .HIST_DEPTH(3), .NRD(2), .CNT_W(8)
  ) u_dut64 (
    .clk            (clk),
    .rst            (rst),
    .MEM_WB_alu_res (alu),
    .MEM_WB_mem_dout(mem),
    .MEM_WB_pc4     (pc),
    .MEM_WB_csr     (csr),
    .MEM_WB_wb_sel  (sel),
    .MEM_WB_size    (size),
    .MEM_WB_unsigned(uns),
    .MEM_WB_vld     (vld),
    .MEM_WB_rd      (rd),
    .q_rs           (q_rs),
    .WB_data        (wb_data64),
    .WB_rd          (wb_rd64),
    .WB_misalign    (mis64),
    .q_hit          (hit64),
    .q_data         (qd64),
    .instret        (ir64)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
  } ent_t;

  ent_t        hq32[$];
  ent_t        hq64[$];
  int unsigned cnt32 = 0;
  int unsigned cnt64 = 0;

  // ---------------- reference model ----------------
  function automatic int nbytes(int xlen);
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return xlen / 8;
    endcase
  endfunction

  function automatic int cur_off(int xlen);
    return int'(alu[2:0]) % (xlen / 8);
  endfunction

  function automatic logic [63:0] ref_wb(int xlen);
    logic [63:0] v;
    int nb, off, start;
    v = '0;
    case (sel)
      2'd0: v = alu;
      2'd2: v = pc;
      2'd3: v = csr;
      default: begin
        nb    = nbytes(xlen);
        off   = cur_off(xlen);
        start = off - (off % nb);
        for (int b = 0; b < nb; b++) v[8*b +: 8] = mem[8*(start+b) +: 8];
        if (!uns && v[8*nb-1]) begin
          for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
        end
      end
    endcase
    if (xlen == 32) v[63:32] = '0;
    return v;
  endfunction

  function automatic logic ref_mis(int xlen);
    return (sel == 2'd1) && vld && ((cur_off(xlen) % nbytes(xlen)) != 0);
  endfunction

  function automatic logic [64:0] ref_look(bit w64, logic [4:0] rs);
    if (rs == 5'd0) return '0;
    if (vld && rd == rs) return {1'b1, ref_wb(w64 ? 64 : 32)};
    if (rst) begin
      if (w64) begin
        for (int i = 0; i < hq64.size(); i++)
          if (hq64[i].rd == rs) return {1'b1, hq64[i].d};
      end else begin
        for (int i = 0; i < hq32.size(); i++)
          if (hq32[i].rd == rs) return {1'b1, hq32[i].d};
      end
    end
    return '0;
  endfunction

  task automatic model_update();
    if (!rst) begin
      hq32.delete();
      hq64.delete();
      cnt32 = 0;
      cnt64 = 0;
    end else begin
      if (vld) begin
        cnt32 = (cnt32 + 1) % 16;
        cnt64 = (cnt64 + 1) % 256;
      end
      if (vld && rd != 5'd0) begin
        hq32.push_front('{rd: rd, d: ref_wb(32)});
        hq64.push_front('{rd: rd, d: ref_wb(64)});
        if (hq32.size() > 2) void'(hq32.pop_back());
        if (hq64.size() > 3) void'(hq64.pop_back());
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [64:0] r;
    chk("wb_data32", 64'(wb_data32), ref_wb(32));
    chk("wb_data64", wb_data64, ref_wb(64));
    chk("wb_rd32", 64'(wb_rd32), vld ? 64'(rd) : 64'd0);
    chk("wb_rd64", 64'(wb_rd64), vld ? 64'(rd) : 64'd0);
    chk("misalign32", 64'(mis32), 64'(ref_mis(32)));
    chk("misalign64", 64'(mis64), 64'(ref_mis(64)));
    for (int p = 0; p < 2; p++) begin
      r = ref_look(1'b0, q_rs[p*5 +: 5]);
      chk("hit32", 64'(hit32[p]), 64'(r[64]));
      chk("qdata32", 64'(qd32[p*32 +: 32]), r[63:0]);
      r = ref_look(1'b1, q_rs[p*5 +: 5]);
      chk("hit64", 64'(hit64[p]), 64'(r[64]));
      chk("qdata64", qd64[p*64 +: 64], r[63:0]);
    end
    chk("instret32", 64'(ir32), 64'(cnt32));
    chk("instret64", 64'(ir64), 64'(cnt64));
  endtask

  // Check current inputs, clock once, advance the model, settle past the edge.
  task automatic cyc();
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst = 1'b0; alu = '0; mem = '0; pc = '0; csr = '0;
    sel = '0; size = '0; uns = 1'b0; vld = 1'b0; rd = '0; q_rs = '0;
    @(posedge clk);
    model_update();
    #1;

    // Reset state
    rst = 1'b1; rd = 5'd9; q_rs = {5'd0, 5'd9};
    #1;
    chk("rst_instret32", 64'(ir32), 64'd0);
    chk("rst_hit32", 64'(hit32), 64'd0);
    chk("inv_wb_rd", 64'(wb_rd32), 64'd0);
    cyc();
    chk("inv_instret", 64'(ir32), 64'd0);
    vld = 1'b1; rd = 5'd0; q_rs = '0;
    cyc();
    chk("rd0_instret", 64'(ir32), 64'd1);
    q_rs = {5'd0, 5'd0}; vld = 1'b0;
    #1;
    chk("rd0_nohist", 64'(hit32), 64'd0);

    // Byte load, signed then unsigned
    sel = 2'd1; size = 2'd0; uns = 1'b0; vld = 1'b1; rd = 5'd1;
    alu = 64'h2; mem = 64'h1280_3456;
    #1;
    chk("byte_s", 64'(wb_data32), 64'hFFFF_FF80);
    chk("byte_mis", 64'(mis32), 64'd0);
    cyc();
    uns = 1'b1;
    #1;
    chk("byte_u", 64'(wb_data32), 64'h0000_0080);
    cyc();

    // Misaligned half load
    size = 2'd1; uns = 1'b0; alu = 64'h3; mem = 64'hBEEF_1234; rd = 5'd8;
    #1;
    chk("half_data", 64'(wb_data32), 64'hFFFF_BEEF);
    chk("half_mis", 64'(mis32), 64'd1);
    chk("half_rd", 64'(wb_rd32), 64'd8);
    cyc();

    // History bypass
    rst = 1'b0; vld = 1'b0;
    #1; cyc();
    rst = 1'b1; sel = 2'd0; vld = 1'b1;
    rd = 5'd5; alu = 64'hA; #1; cyc();
    alu = 64'hB; #1; cyc();
    rd = 5'd7; alu = 64'hC; #1; cyc();
    vld = 1'b0; q_rs = {5'd7, 5'd5};
    #1;
    chk("bypass_hit", 64'(hit32), 64'd3);
    chk("bypass_data", qd32, {32'hC, 32'hB});
    cyc();
    vld = 1'b1; rd = 5'd6; alu = 64'h6; q_rs = '0;
    #1; cyc();
    vld = 1'b0; q_rs = {5'd0, 5'd5};
    #1;
    chk("aged_out32", 64'(hit32[0]), 64'd0);
    chk("deep_hit64", 64'(hit64[0]), 64'd1);
    chk("deep_data64", qd64[63:0], 64'hB);
    cyc();

    // Same-cycle priority over history
    vld = 1'b1; rd = 5'd3; alu = 64'h1; q_rs = '0;
    #1; cyc();
    alu = 64'h2; q_rs = {5'd0, 5'd3};
    #1;
    chk("prio_hit", 64'(hit32[0]), 64'd1);
    chk("prio_data", 64'(qd32[31:0]), 64'h2);
    cyc();
    rd = 5'd0; q_rs = '0;
    #1;
    chk("x0_hit", 64'(hit32[0]), 64'd0);
    cyc();

    // Counter wrap
    rst = 1'b0; #1; cyc();
    rst = 1'b1; vld = 1'b1; rd = 5'd0;
    for (int n = 0; n < 16; n++) begin
      #1; cyc();
    end
    chk("wrap32", 64'(ir32), 64'd0);
    chk("wrap64", 64'(ir64), 64'd16);

    // Reset asserted during a commit
    rd = 5'd4; alu = 64'h33; #1; cyc();
    rst = 1'b0; alu = 64'h44; q_rs = {5'd0, 5'd4};
    #1;
    chk("rst_cur_hit", 64'(hit32[0]), 64'd1);
    chk("rst_cur_data", 64'(qd32[31:0]), 64'h44);
    cyc();
    rst = 1'b1; vld = 1'b0;
    #1;
    chk("rst_clr_hit", 64'(hit32[0]), 64'd0);
    chk("rst_clr_cnt", 64'(ir32), 64'd0);
    cyc();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 39) != 0);
      alu  = {$urandom, $urandom};
      mem  = {$urandom, $urandom};
      pc   = {$urandom, $urandom};
      csr  = {$urandom, $urandom};
      sel  = ($urandom_range(0, 1) != 0) ? 2'd1 : 2'($urandom_range(0, 3));
      size = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      vld  = ($urandom_range(0, 3) != 0);
      rd   = 5'($urandom_range(0, 7));
      q_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage_fwd.md
Name: wb_stage_fwd

Overview:
Parametrised writeback stage that generalises the single-cycle writeback mux. It selects among ALU, load, PC+4 and CSR sources, and extracts, aligns and sign- or zero-extends sub-word loads. It drives the register-file write port and keeps a HIST_DEPTH-entry history of committed writes, so decode read ports get a bypass one or more cycles after writeback. It also keeps a retired-instruction counter. It sits between the MEM/WB pipeline register and the register file / decode stage.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
RBITS, 5, register index width.
HIST_DEPTH, 2, number of committed writes retained for bypass; minimum 1.
NRD, 2, number of decode lookup ports.
CNT_W, 64, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-low; sampled on the rising clk edge.
MEM_WB_alu_res  in  XLEN  ALU result; its low bits are the load byte offset.
MEM_WB_mem_dout  in  XLEN  raw naturally-aligned memory word.
MEM_WB_pc4  in  XLEN  PC+4 for link writes.
MEM_WB_csr  in  XLEN  CSR read value.
MEM_WB_wb_sel  in  2  source select: 00 ALU, 01 MEM, 10 PC4, 11 CSR.
MEM_WB_size  in  2  load size: 00 byte, 01 half, 10 word, 11 dword.
MEM_WB_unsigned  in  1  1 selects zero-extension for loads.
MEM_WB_vld  in  1  instruction in WB is valid.
MEM_WB_rd  in  RBITS  destination register.
q_rs  in  NRD*RBITS  lookup indices; port i occupies bits [i*RBITS +: RBITS].
WB_data  out  XLEN  write data (combinational).
WB_rd  out  RBITS  write index; 0 when not valid (combinational).
WB_misalign  out  1  load offset not aligned to its size (combinational).
q_hit  out  NRD  bypass hit per port.
q_data  out  NRD*XLEN  bypass data per port.
instret  out  CNT_W  retired-instruction count.

Behaviour:
- Offset width OB = log2(XLEN/8); off = MEM_WB_alu_res[OB-1:0].
- Byte load: takes mem_dout[8*off +: 8].
- Half load: takes the halfword at the offset with bit 0 forced to 0. WB_misalign = off[0].
- Word load:
  - XLEN=32: returns the whole word.
  - XLEN=64: takes the word at the offset with bits [1:0] forced to 0.
  - WB_misalign = |off[1:0].
- Dword load:
  - XLEN=64: returns the whole word; WB_misalign = |off.
  - XLEN=32: treated as word.
- Extension: sign-extend from the loaded MSB unless MEM_WB_unsigned=1, in which case zero-extend.
- WB_misalign is 0 unless wb_sel=01 and MEM_WB_vld=1. It is informational only: the aligned-down data is still written.
- WB_data = the selected source, with the load path used when sel=01. It is valid regardless of vld.
- WB_rd = MEM_WB_rd when vld=1, else 0.
- Commit: the current cycle commits when vld=1 and MEM_WB_rd!=0.
- History: shift register of {valid, rd, data}, entry 0 newest.
  - On a commit, at the clock edge: entry0 <= {1, WB_rd, WB_data} and entry k <= entry k-1.
  - Without a commit, the history holds.
  - Reset clears all valid bits. Stored data and rd are don't-care after reset.
- Lookup, combinational, per port i:
  - q_rs_i = 0 always gives q_hit_i = 0 and q_data_i = 0.
  - Priority: current-cycle commit, then entry0, then entry1, and so on.
  - The first rd match wins, supplying its data.
  - No match gives hit=0 and data=0.
  - Duplicate rd in history: the newest entry wins.
- instret: increments by 1 at every clock edge where vld=1, including rd=0 and misaligned loads.
  - Wraps modulo 2^CNT_W without a flag.
  - Reset value 0.
- Reset values:
  - Registered outputs: instret=0, all history entries invalid.
  - Combinational outputs follow their inputs during reset; q_hit reflects only the current-cycle commit.
- Reset mid-operation: an asserted rst wins over a simultaneous commit. The history is cleared and the counter goes to 0 on that edge.

Test Plan:
- Byte load: XLEN=32, sel=01, size=00, unsigned=0, alu_res=0x...2, mem_dout=0x12_80_34_56 -> WB_data=0xFFFFFF80, WB_misalign=0. Same stimulus with unsigned=1 -> 0x00000080.
- Half load: size=01, off=3, mem_dout=0xBEEF1234 -> WB_data=0xFFFFBEEF, WB_misalign=1, WB_rd=MEM_WB_rd.
- History bypass, HIST_DEPTH=2:
  - Commits x5=0xA, x5=0xB, x7=0xC over three cycles.
  - Then lookup with vld=0, q_rs={5,7} -> hit=11, data={0xB,0xC}.
  - Next cycle, commit x6, then lookup x5 -> hit=0 (entry aged out).
- Same-cycle priority: entry0 holds x3=0x1; current commit is x3=0x2 -> q_data=0x2. A lookup of x0 while committing x0 (WB_rd=0, no commit) -> hit=0.
- Invalid instruction: vld=0, rd=9 -> WB_rd=0, history unchanged, instret unchanged. A vld=1, rd=0 instruction -> instret increments and history is unchanged.
- Reset and wrap:
  - CNT_W=4, 16 valid cycles -> instret=0.
  - Assert rst low during a commit of x4 -> next cycle lookup x4 gives hit=0 and instret=0.
